// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths and state encoding for the jump-target stage
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int JTARGET_W   = 26;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } jreg_state_t;

endpackage

`default_nettype wire

// File: rtl/dff_en_arn.sv
// ============================================================================
// dff_en_arn : W-bit enabled register, async active-low clear plus sync clear
// Rev 1.0
// ============================================================================
`default_nettype none

module dff_en_arn #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Sync clear outranks the enable so a flush always empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jreg_pipe_ctrl.sv
// ============================================================================
// jreg_pipe_ctrl : valid/ready pipeline stage with 2-entry skid, flush and an
// optional back-pressure counter enabled by JREG_STALL_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module jreg_pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int W     = JTARGET_W,
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef JREG_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [W-1:0]     out_data
);

    jreg_state_t r_state;
    jreg_state_t w_state_nxt;
    logic        w_in_acc;
    logic        w_out_acc;
    logic        w_head_en;
    logic        w_head_from_skid;
    logic        w_skid_en;
    logic [W-1:0] w_head_d;
    logic [W-1:0] r_skid;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign w_in_acc  = in_valid & in_ready;
    assign w_out_acc = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_acc) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_in_acc && !w_out_acc)      w_state_nxt = ST_TWO;
                    else if (w_out_acc && !w_in_acc) w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_out_acc) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Ready/valid depend on the state register alone, never on out_ready.
    always_comb begin
        in_ready         = (r_state != ST_TWO);
        out_valid        = (r_state != ST_EMPTY);
        w_head_en        = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        case (r_state)
            ST_EMPTY: w_head_en = w_in_acc;
            ST_ONE: begin
                w_head_en = w_in_acc & w_out_acc;
                w_skid_en = w_in_acc & ~w_out_acc;
            end
            ST_TWO: begin
                w_head_en        = w_out_acc;
                w_head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_head_d = w_head_from_skid ? r_skid : in_data;

    dff_en_arn #(.W(W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (w_head_en),
        .d     (w_head_d),
        .q     (out_data)
    );

    dff_en_arn #(.W(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (w_skid_en),
        .d     (in_data),
        .q     (r_skid)
    );

`ifdef JREG_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating; flush deliberately leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jreg_pipe_ctrl.sv
// ============================================================================
// tb_jreg_pipe_ctrl : directed and random checks of jreg_pipe_ctrl against a
// queue-based 2-deep FIFO model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jreg_pipe_ctrl;

    localparam int W     = 26;
    localparam int CNT_W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef JREG_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int chk = 0;
    int pass = 0;

    logic [W-1:0] q[$];
    bit           exp_zero = 1'b1;

    always #5 clk = ~clk;

    jreg_pipe_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef JREG_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_data  (out_data)
    );

    // One clock of stimulus; the FIFO model advances with the same inputs.
    task automatic step();
        bit           ia;
        bit           oa;
        logic [W-1:0] d;
        ia = in_valid && (q.size() < 2);
        oa = (q.size() > 0) && out_ready;
        d  = in_data;
        @(posedge clk);
        if (flush) begin
            q.delete();
            exp_zero = 1'b1;
        end else begin
            if (oa) void'(q.pop_front());
            if (ia) begin
                q.push_back(d);
                exp_zero = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
            $display("FAIL reset_state: valid=%b ready=%b data=%h, want 0/1/0", out_valid, in_ready, out_data);
        else pass++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h0000123;
        step();
        in_data   = 26'h0000456;
        step();
        in_valid  = 1'b0;
        chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL reset_mid_fill: ready=%b valid=%b, want 0/1", in_ready, out_valid);
        else pass++;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        exp_zero = 1'b1;
        chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
            $display("FAIL reset_async: valid=%b ready=%b data=%h, want 0/1/0", out_valid, in_ready, out_data);
        else pass++;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 26'h3FFFFFF;
        step();
        in_valid = 1'b0;
        chk++;
        if (out_valid !== 1'b1 || out_data !== 26'h3FFFFFF)
            $display("FAIL reset_first_accept: valid=%b data=%h, want 1/3ffffff", out_valid, out_data);
        else pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data  = W'(k);
            step();
            chk++;
            if (out_valid !== 1'b1 || out_data !== W'(k) || in_ready !== 1'b1)
                $display("FAIL stream_%0d: valid=%b data=%h ready=%b, want 1/%h/1", k, out_valid, out_data, in_ready, W'(k));
            else pass++;
        end
        in_valid = 1'b0;
        step();
        chk++;
        if (out_valid !== 1'b0)
            $display("FAIL stream_drain: valid=%b, want 0", out_valid);
        else pass++;
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h0000AAA;
        step();
        in_data   = 26'h1555555;
        step();
        in_data   = 26'h0BADBAD;
        step();
        chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 26'h0000AAA)
            $display("FAIL skid_full: ready=%b valid=%b data=%h, want 0/1/0000aaa", in_ready, out_valid, out_data);
        else pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk++;
        if (out_valid !== 1'b1 || out_data !== 26'h1555555 || in_ready !== 1'b1)
            $display("FAIL skid_second: valid=%b data=%h ready=%b, want 1/1555555/1", out_valid, out_data, in_ready);
        else pass++;
        step();
        chk++;
        if (out_valid !== 1'b0)
            $display("FAIL skid_empty: valid=%b, want 0", out_valid);
        else pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h0111111;
        step();
        in_data   = 26'h0222222;
        step();
        flush     = 1'b1;
        in_data   = 26'h0333333;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
            $display("FAIL flush_state: valid=%b ready=%b data=%h, want 0/1/0", out_valid, in_ready, out_data);
        else pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_no_ghost: valid=%b data=%h, want valid 0", out_valid, out_data);
        else pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int           errs;
        bit           held;
        logic [W-1:0] held_data;
        errs = 0;
        held = 1'b0;
        held_data = '0;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = W'($urandom);
            held      = out_valid && !out_ready && !flush;
            held_data = out_data;
            step();
            chk++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                if (errs < 10)
                    $display("FAIL rand_flags cyc %0d: valid=%b ready=%b, want %b/%b", i, out_valid, in_ready, q.size() > 0, q.size() < 2);
                errs++;
            end else pass++;
            chk++;
            if (q.size() > 0 ? (out_data !== q[0]) : (exp_zero && out_data !== '0)) begin
                if (errs < 10)
                    $display("FAIL rand_data cyc %0d: data=%h, want %h", i, out_data, q.size() > 0 ? q[0] : '0);
                errs++;
            end else pass++;
            if (held) begin
                chk++;
                if (out_data !== held_data) begin
                    if (errs < 10)
                        $display("FAIL rand_stable cyc %0d: data=%h, want %h", i, out_data, held_data);
                    errs++;
                end else pass++;
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
    endtask

`ifdef JREG_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_n = 1'b0;
        #3;
        q.delete();
        exp_zero = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h00000C5;
        step();
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk++;
        if (stall_cnt !== 16'd5)
            $display("FAIL stall_count5: cnt=%0d, want 5", stall_cnt);
        else pass++;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        chk++;
        if (stall_cnt !== 16'hFFFF || out_data !== 26'h00000C5)
            $display("FAIL stall_saturate: cnt=%h data=%h, want ffff/00000c5", stall_cnt, out_data);
        else pass++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk++;
        if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0)
            $display("FAIL stall_flush: cnt=%h valid=%b, want ffff/0", stall_cnt, out_valid);
        else pass++;
        #2 rst_n = 1'b0;
        #1;
        chk++;
        if (stall_cnt !== '0)
            $display("FAIL stall_reset: cnt=%h, want 0", stall_cnt);
        else pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset_midstream();
        test_stream();
        test_skid();
        test_flush();
        test_random();
`ifdef JREG_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

`default_nettype wire
